// File: rtl/mips_run_controller_pkg.sv
// Shared types for the MIPS run controller: sequencer states, completion
// reasons and the register-number width.
package mips_run_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    SENTINEL = 2'd1,
    HALT     = 2'd2,
    TIMEOUT  = 2'd3
  } reason_e;

endpackage

// File: rtl/mips_run_controller_if.sv
// Control/status bundle between the run controller (master) and the core or
// bench side (slave).
interface mips_run_controller_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  import mips_run_pkg::*;

  logic                 restart;
  logic [PC_WIDTH-1:0]  pc;
  logic                 wb_valid;
  logic [REG_W-1:0]     wb_reg;
  logic [31:0]          wb_data;

  logic                 core_reset;
  logic                 running;
  logic                 done;
  reason_e              reason;
  logic                 pass;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] wb_count;

  modport master (
    input  restart, pc, wb_valid, wb_reg, wb_data,
    output core_reset, running, done, reason, pass, cycle_count, wb_count
  );

  modport slave (
    output restart, pc, wb_valid, wb_reg, wb_data,
    input  core_reset, running, done, reason, pass, cycle_count, wb_count
  );

endinterface

// File: rtl/mips_run_controller_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mips_run_controller.sv
// Run sequencer for the pipelined MIPS core: holds the core in reset, then
// runs it until a sentinel write, a stalled PC or the watchdog ends the run.
module mips_run_controller
  import mips_run_pkg::*;
#(
  parameter int               RESET_CYCLES   = 2,
  parameter int               TIMEOUT_CYCLES = 1000,
  parameter int               HALT_REPEAT    = 4,
  parameter int               PC_WIDTH       = 32,
  parameter int               CNT_WIDTH      = 32,
  parameter logic [REG_W-1:0] SENTINEL_REG   = 5'd2,
  parameter logic [31:0]      PASS_VALUE     = 32'h1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mips_run_controller_if.master bus
);

  localparam logic [7:0]           HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0]           HALT_LAST = 8'(HALT_REPEAT - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e               state;
  logic                 core_reset_q, running_q, done_q, pass_q;
  reason_e              reason_q;
  logic [7:0]           hold_cnt, halt_cnt;
  logic [CNT_WIDTH-1:0] cycle_cnt, wb_cnt;
  logic [PC_WIDTH-1:0]  prev_pc;

  logic in_hold, in_run, in_done, do_restart, hold_last, pc_same;
  logic hit_sentinel, hit_halt, hit_timeout, wb_counted;

  always_comb begin
    in_hold      = (state == HOLD);
    in_run       = (state == RUN);
    in_done      = (state == DONE);
    do_restart   = in_done && bus.restart;
    hold_last    = in_hold && (hold_cnt == HOLD_LAST);
    pc_same      = (bus.pc == prev_pc);
    wb_counted   = in_run && bus.wb_valid && (bus.wb_reg != '0);
    hit_sentinel = in_run && bus.wb_valid && (bus.wb_reg == SENTINEL_REG)
                   && (SENTINEL_REG != '0);
    // halt_cnt holds the streak before this cycle, so this is the HALT_REPEAT-th equal PC
    hit_halt     = in_run && pc_same && (halt_cnt == HALT_LAST);
    hit_timeout  = in_run && (TIMEOUT_CYCLES != 0) && (cycle_cnt == TO_LAST);
  end

  sat_counter #(.WIDTH(8)) u_hold_cnt (
    .clock(clock), .reset_n(reset_n),
    .clr(!in_hold || hold_last), .en(in_hold), .count(hold_cnt)
  );

  sat_counter #(.WIDTH(8)) u_halt_cnt (
    .clock(clock), .reset_n(reset_n),
    .clr(!in_run || !pc_same), .en(in_run && pc_same), .count(halt_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clock(clock), .reset_n(reset_n),
    .clr(do_restart), .en(in_run), .count(cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clock(clock), .reset_n(reset_n),
    .clr(do_restart), .en(wb_counted), .count(wb_cnt)
  );

  // Frozen in DONE so the last PC stays visible to the comparison after restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_pc <= '0;
    end else if (!in_done) begin
      prev_pc <= bus.pc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= HOLD;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      reason_q     <= NONE;
      pass_q       <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_last) begin
            state        <= RUN;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end
        end
        RUN: begin
          if (hit_sentinel || hit_halt || hit_timeout) begin
            state     <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            if (hit_sentinel) begin
              reason_q <= SENTINEL;
              pass_q   <= (bus.wb_data == PASS_VALUE);
            end else if (hit_halt) begin
              reason_q <= HALT;
            end else begin
              reason_q <= TIMEOUT;
            end
          end
        end
        DONE: begin
          if (bus.restart) begin
            state        <= HOLD;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            reason_q     <= NONE;
            pass_q       <= 1'b0;
          end
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.reason      = reason_q;
  assign bus.pass        = pass_q;
  assign bus.cycle_count = cycle_cnt;
  assign bus.wb_count    = wb_cnt;

endmodule

// File: tb/tb_mips_run_controller.sv
// Bench for mips_run_controller: directed run table, randomized runs against
// a per-run reference scan, restart and asynchronous reset sequences.
module tb_mips_run_controller;
  import mips_run_pkg::*;

  localparam int RC   = 2;
  localparam int TO   = 16;
  localparam int HR   = 4;
  localparam int MAXC = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mips_run_controller_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bus ();

  mips_run_controller #(
    .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .HALT_REPEAT(HR),
    .PC_WIDTH(32), .CNT_WIDTH(32), .SENTINEL_REG(5'd2), .PASS_VALUE(32'h1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          sent_at;    // -1: no sentinel write
    logic [31:0] sent_data;
    int          stall_from; // -1: PC always advances; 0: stalled from HOLD on
    int          wr_reg;     // -1: no background writes
    int          e_reason;
    bit          e_pass;
    int          e_cycles;
    int          e_wbs;
  } vec_t;

  logic [31:0] s_pc [MAXC];
  bit          s_v  [MAXC];
  logic [4:0]  s_r  [MAXC];
  logic [31:0] s_d  [MAXC];
  logic [31:0] s_hold_pc;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.restart  = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_reg   = '0;
    bus.wb_data  = '0;
  endtask

  task automatic load_vec(vec_t v);
    logic [31:0] base;
    base = 32'h40;
    for (int i = 0; i < MAXC; i++) begin
      if (v.stall_from >= 0 && i >= v.stall_from) s_pc[i] = base + 32'(4 * v.stall_from);
      else                                        s_pc[i] = base + 32'(4 * i);
      s_v[i] = (v.wr_reg >= 0);
      s_r[i] = (v.wr_reg >= 0) ? 5'(v.wr_reg) : 5'd0;
      s_d[i] = 32'hdead_0000 + 32'(i);
      if (i == v.sent_at) begin
        s_v[i] = 1'b1;
        s_r[i] = 5'd2;
        s_d[i] = v.sent_data;
      end
    end
    s_hold_pc = (v.stall_from == 0) ? base : base - 32'd4;
  endtask

  // Scan a whole run: first cycle that satisfies a stop rule, in priority order.
  task automatic ref_model(output int rsn, output bit ps, output int cyc, output int wbs);
    int          streak;
    logic [31:0] prev;
    streak = 0; prev = s_hold_pc; wbs = 0; rsn = 0; ps = 1'b0; cyc = 0;
    for (int i = 0; i < MAXC; i++) begin
      if (s_v[i] && s_r[i] != 5'd0) wbs++;
      streak = (s_pc[i] == prev) ? streak + 1 : 0;
      prev   = s_pc[i];
      cyc    = i + 1;
      if (s_v[i] && s_r[i] == 5'd2) begin rsn = 1; ps = (s_d[i] == 32'h1); return; end
      if (streak >= HR)             begin rsn = 2; return; end
      if (cyc == TO)                begin rsn = 3; return; end
    end
  endtask

  // Starts on the edge that entered HOLD; ends after the restart edge.
  task automatic exec_run(string tag, int er, bit ep, int ec, int ew);
    int end_i;
    end_i = -1;
    drive_idle();
    bus.pc = s_hold_pc;
    tick();
    check($sformatf("%s.hold_core_reset", tag), bus.core_reset, 1'b1);
    check($sformatf("%s.hold_running", tag), bus.running, 1'b0);
    tick();
    check($sformatf("%s.run_core_reset", tag), bus.core_reset, 1'b0);
    check($sformatf("%s.run_running", tag), bus.running, 1'b1);
    check($sformatf("%s.run_cycle0", tag), bus.cycle_count, 0);
    for (int i = 0; i < MAXC + 4 && end_i < 0; i++) begin
      int k;
      k = (i < MAXC) ? i : MAXC - 1;
      bus.pc       = s_pc[k];
      bus.wb_valid = s_v[k];
      bus.wb_reg   = s_r[k];
      bus.wb_data  = s_d[k];
      tick();
      if (bus.done) end_i = i;
    end
    drive_idle();
    check($sformatf("%s.finished", tag), (end_i >= 0), 1'b1);
    check($sformatf("%s.reason", tag), bus.reason, er);
    check($sformatf("%s.pass", tag), bus.pass, ep);
    check($sformatf("%s.cycle_count", tag), bus.cycle_count, ec);
    check($sformatf("%s.wb_count", tag), bus.wb_count, ew);
    check($sformatf("%s.done_running", tag), {bus.running, bus.core_reset}, 2'b00);
    repeat (3) begin
      bus.pc = $urandom; bus.wb_valid = 1'b1; bus.wb_reg = 5'd5;
      tick();
    end
    drive_idle();
    check($sformatf("%s.frozen_cycles", tag), bus.cycle_count, ec);
    check($sformatf("%s.frozen_wb", tag), bus.wb_count, ew);
    check($sformatf("%s.frozen_done", tag), {bus.done, bus.reason}, {1'b1, 2'(er)});
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check($sformatf("%s.restart_flags", tag),
          {bus.done, bus.core_reset, bus.running, bus.pass}, 4'b0100);
    check($sformatf("%s.restart_counts", tag), {bus.cycle_count, bus.wb_count}, 0);
    check($sformatf("%s.restart_reason", tag), bus.reason, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    vec_t vecs [11];
    int   rr, rc, rw;
    bit   rp;
    vecs[0]  = '{"sent_pass",        10, 32'h1, -1, -1, 1, 1'b1, 11, 1};
    vecs[1]  = '{"sent_beats_halt",  10, 32'h7,  6, -1, 1, 1'b0, 11, 1};
    vecs[2]  = '{"halt_only",        -1, 32'h0,  6, -1, 2, 1'b0, 11, 0};
    vecs[3]  = '{"halt_r0_writes",   -1, 32'h0,  0,  0, 2, 1'b0,  4, 0};
    vecs[4]  = '{"timeout",          -1, 32'h0, -1, -1, 3, 1'b0, 16, 0};
    vecs[5]  = '{"timeout_wb",       -1, 32'h0, -1,  5, 3, 1'b0, 16, 16};
    vecs[6]  = '{"sent_first_cycle",  0, 32'h1, -1, -1, 1, 1'b1,  1, 1};
    vecs[7]  = '{"sent_vs_timeout",  15, 32'h2, -1, -1, 1, 1'b0, 16, 1};
    vecs[8]  = '{"short_stall",      -1, 32'h0, 12, -1, 3, 1'b0, 16, 0};
    vecs[9]  = '{"halt_vs_timeout",  -1, 32'h0, 11, -1, 2, 1'b0, 16, 0};
    vecs[10] = '{"sent_with_wb",      4, 32'h1, -1,  5, 1, 1'b1,  5, 5};

    drive_idle();
    bus.pc = '0;
    #12;
    check("reset_flags", {bus.core_reset, bus.running, bus.done, bus.pass}, 4'b1000);
    check("reset_reason", bus.reason, 0);
    check("reset_counts", {bus.cycle_count, bus.wb_count}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      load_vec(vecs[v]);
      exec_run(vecs[v].name, vecs[v].e_reason, vecs[v].e_pass,
               vecs[v].e_cycles, vecs[v].e_wbs);
    end

    for (int n = 0; n < 40; n++) begin
      logic [31:0] p;
      s_hold_pc = 32'($urandom_range(0, 3) * 4);
      p = s_hold_pc;
      for (int i = 0; i < MAXC; i++) begin
        if ($urandom_range(0, 1) == 1) p = p + 32'(4 * $urandom_range(1, 2));
        s_pc[i] = p;
        s_v[i]  = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 4))
          0:       s_r[i] = 5'd0;
          1:       s_r[i] = 5'd1;
          2:       s_r[i] = 5'd2;
          3:       s_r[i] = 5'd3;
          default: s_r[i] = 5'd5;
        endcase
        s_d[i] = ($urandom_range(0, 2) == 0) ? 32'h1 : 32'($urandom_range(0, 3));
      end
      ref_model(rr, rp, rc, rw);
      exec_run($sformatf("rand%0d", n), rr, rp, rc, rw);
    end

    // restart mid-RUN is ignored, then async reset between edges
    drive_idle();
    bus.pc = 32'h80;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.pc = 32'h100 + 32'(4 * i);
      bus.restart = (i == 3);
      tick();
    end
    bus.restart = 1'b0;
    check("run_restart_ignored", {bus.running, bus.done, bus.core_reset}, 3'b100);
    check("run_restart_count", bus.cycle_count, 4);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_run_flags", {bus.core_reset, bus.running, bus.done}, 3'b100);
    check("async_run_count", bus.cycle_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    load_vec(vecs[0]);
    exec_run("after_async", 1, 1'b1, 11, 1);

    // async reset while in DONE
    drive_idle();
    bus.pc = 32'h40;
    tick();
    tick();
    bus.pc = 32'h44; bus.wb_valid = 1'b1; bus.wb_reg = 5'd2; bus.wb_data = 32'h1;
    tick();
    drive_idle();
    check("pre_async_done", {bus.done, bus.reason, bus.pass}, {1'b1, 2'd1, 1'b1});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_done_flags", {bus.core_reset, bus.done, bus.pass}, 3'b100);
    check("async_done_reason", bus.reason, 0);
    check("async_done_count", {bus.cycle_count, bus.wb_count}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
